// File: rtl/fwd_bypass_if.sv
// Operand-forwarding bus between the ID-stage controller and fwd_bypass_net.
// master drives the pipeline view; slave is the forwarding network.
interface fwd_bypass_if #(
    parameter int unsigned DW     = 32,
    parameter int unsigned AW     = 5,
    parameter int unsigned NSTAGE = 2,
    parameter int unsigned NPORT  = 2
);
    localparam int unsigned SW = $clog2(NSTAGE + 2);

    logic                  hold;
    logic                  flush;
    logic                  ex_we;
    logic [AW-1:0]         ex_waddr;
    logic                  ex_is_load;
    logic [DW-1:0]         ex_wdata;
    logic [DW-1:0]         mem_rdata;
    logic [NPORT-1:0]      rd_en;
    logic [NPORT*AW-1:0]   rd_addr;
    logic [NPORT*DW-1:0]   rf_rdata;
    logic [NPORT*DW-1:0]   op_data;
    logic [NPORT*SW-1:0]   fwd_src;
    logic                  lu_stall;
    logic [31:0]           stat_fwd;
    logic [31:0]           stat_stall;

    modport master (
        output hold, flush, ex_we, ex_waddr, ex_is_load, ex_wdata, mem_rdata,
               rd_en, rd_addr, rf_rdata,
        input  op_data, fwd_src, lu_stall, stat_fwd, stat_stall
    );

    modport slave (
        input  hold, flush, ex_we, ex_waddr, ex_is_load, ex_wdata, mem_rdata,
               rd_en, rd_addr, rf_rdata,
        output op_data, fwd_src, lu_stall, stat_fwd, stat_stall
    );
endinterface

// File: rtl/fwd_bypass_net.sv
// Generalised operand-forwarding network: tracks in-flight writes MEM..WB and
// returns the youngest value per read port. Optional counters under FWD_STATS_EN.
module fwd_bypass_net #(
    parameter int unsigned DW     = 32,
    parameter int unsigned AW     = 5,
    parameter int unsigned NSTAGE = 2,
    parameter int unsigned NPORT  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    fwd_bypass_if.slave   bus
);
    localparam int unsigned SW = $clog2(NSTAGE + 2);

    typedef struct packed {
        logic          v;
        logic [AW-1:0] addr;
        logic          load;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        stg_q    [NSTAGE];
    logic [DW-1:0] stg_data [NSTAGE];
    entry_t        s0_in;
    entry_t        s1_in;
    logic          adv;

    logic [NPORT*DW-1:0] op_data;
    logic [NPORT*SW-1:0] fwd_src;
    logic [NPORT-1:0]    haz;

    // flush dominates hold: a bubble still shifts in
    assign adv = !bus.hold || bus.flush;

    always_comb begin
        s0_in      = '0;
        s0_in.v    = bus.ex_we && !bus.flush && (bus.ex_waddr != '0);
        s0_in.addr = bus.ex_waddr;
        s0_in.load = bus.ex_is_load;
        s0_in.data = bus.ex_wdata;
        s1_in      = stg_q[0];
        if (stg_q[0].load) begin
            s1_in.data = bus.mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSTAGE; k++) begin
                stg_q[k] <= '0;
            end
        end else if (adv) begin
            stg_q[0] <= s0_in;
            for (int k = 1; k < NSTAGE; k++) begin
                stg_q[k] <= (k == 1) ? s1_in : stg_q[k-1];
            end
        end
    end

    // MEM stage forwards live load data; later stages already hold resolved data
    always_comb begin
        for (int k = 0; k < NSTAGE; k++) begin
            stg_data[k] = stg_q[k].data;
        end
        if (stg_q[0].load) begin
            stg_data[0] = bus.mem_rdata;
        end
    end

    // Per-port lookup; descending scan lets the smallest matching k win
    always_comb begin
        op_data = bus.rf_rdata;
        fwd_src = '0;
        haz     = '0;
        for (int p = 0; p < NPORT; p++) begin
            if (bus.rd_en[p] && (bus.rd_addr[p*AW +: AW] != '0)) begin
                if (bus.ex_we && (bus.ex_waddr == bus.rd_addr[p*AW +: AW])) begin
                    fwd_src[p*SW +: SW] = SW'(1);
                    op_data[p*DW +: DW] = bus.ex_wdata;
                    haz[p]              = bus.ex_is_load;
                end else begin
                    for (int k = NSTAGE - 1; k >= 0; k--) begin
                        if (stg_q[k].v && (stg_q[k].addr == bus.rd_addr[p*AW +: AW])) begin
                            fwd_src[p*SW +: SW] = SW'(k + 2);
                            op_data[p*DW +: DW] = stg_data[k];
                        end
                    end
                end
            end
        end
    end

    assign bus.op_data  = op_data;
    assign bus.fwd_src  = fwd_src;
    assign bus.lu_stall = |haz;

`ifdef FWD_STATS_EN
    localparam int unsigned CW = $clog2(NPORT + 1);

    logic [CW-1:0] fwd_cnt;
    logic [32:0]   fwd_sum;
    logic [31:0]   stat_fwd_q;
    logic [31:0]   stat_stall_q;

    always_comb begin
        fwd_cnt = '0;
        for (int p = 0; p < NPORT; p++) begin
            if ((fwd_src[p*SW +: SW] != '0) && !haz[p]) begin
                fwd_cnt = fwd_cnt + CW'(1);
            end
        end
    end

    assign fwd_sum = {1'b0, stat_fwd_q} + 33'(fwd_cnt);

    // Saturating counters, deliberately not gated by hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fwd_q   <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_fwd_q <= fwd_sum[32] ? 32'hFFFF_FFFF : fwd_sum[31:0];
            if (bus.lu_stall && (stat_stall_q != 32'hFFFF_FFFF)) begin
                stat_stall_q <= stat_stall_q + 32'd1;
            end
        end
    end

    assign bus.stat_fwd   = stat_fwd_q;
    assign bus.stat_stall = stat_stall_q;
`else
    assign bus.stat_fwd   = '0;
    assign bus.stat_stall = '0;
`endif

endmodule
